fdl_ctrl: RTL and testbench
===========================

# fdl_ctrl

Sequencing controller for the 6-bit fine delay line. It samples the DLL phase detector, runs a 6-step successive-approximation search, then tracks ±1 LSB, and drives the complementary thermometer-free binary control pair `Q`/`Qb`. It flags lock and requests a coarse-stage step via a req/ack handshake when the fine range is exhausted. It sits between the phase detector and the fine delay line, clocked by the reference clock domain.

## Interface
- `SETTLE_CYC`, default 8: cycles waited after every code change before the phase detector is sampled (≥1).
- `LOCK_CNT`, default 4: consecutive direction reversals in TRACK required to assert `locked` (≥1).
- `MID_CODE`, default 6'd32: code loaded at SAR start and after a coarse step.

Ports:
- `clk_in` in 1: controller clock. Single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: run controller. Low forces IDLE on the next edge.
- `pd_up` in 1: phase detector, increase delay. Already synchronized.
- `pd_dn` in 1: phase detector, decrease delay. Already synchronized.
- `coarse_ack` in 1: coarse stage acknowledges a step request.
- `Q` out 6: fine delay code, registered.
- `Qb` out 6: bitwise complement of `Q`, registered on the same edge.
- `locked` out 1: DLL fine loop locked.
- `coarse_inc` out 1: request one coarse delay step up (level, held until ack).
- `coarse_dec` out 1: request one coarse delay step down (level, held until ack).

## Operation
- Reset values: `Q`=`MID_CODE`, `Qb`=~`MID_CODE`, `locked`=0, `coarse_inc`=0, `coarse_dec`=0, state IDLE, settle counter 0, reversal counter 0.
- Move decode at a sample point:
  - `pd_up`&!`pd_dn` = UP.
  - `pd_dn`&!`pd_up` = DN.
  - Both or neither = HOLD.
- States:
  - **IDLE**: outputs hold. On `enable`=1: `Q`←`MID_CODE`, bit index←5, settle reload, go to SAR.
  - **SAR**: at each sample point, if DN clear bit[idx]; UP and HOLD keep it. Then, if idx>0, set bit[idx-1], idx←idx-1, and reload settle. After bit 0 is resolved: go to TRACK, reload settle.
  - **TRACK**: at each sample point:
    - UP with `Q`<63: `Q`+1.
    - DN with `Q`>0: `Q`−1.
    - HOLD: no change. Settle is still reloaded.
    - UP at `Q`=63: go to COARSE with `coarse_inc`=1.
    - DN at `Q`=0: go to COARSE with `coarse_dec`=1.
    - `Q` never wraps.
  - **COARSE**: hold the request until `coarse_ack`=1 is sampled. On that edge: request←0, `Q`←`MID_CODE`, settle reload, go to TRACK.
- Lock logic (TRACK only):
  - A move opposite to the previous move increments the reversal counter, saturating at `LOCK_CNT`.
  - A move in the same direction as the previous move clears the counter and `locked`.
  - HOLD leaves both unchanged.
  - `locked`←1 when the counter reaches `LOCK_CNT`.
  - Entering COARSE, IDLE or SAR clears the counter and `locked`.
- `enable`=0 in any state → IDLE next edge. Any pending coarse request drops; `Q` is held. Re-enable restarts the SAR.
- `rst_n`=0 mid-operation → all reset values on that edge, regardless of handshake state.

## Timing
- `Q` and `Qb` change on the same edge. `Qb`==~`Q` on every cycle, including reset.
- A sample point is the cycle in which the settle counter equals 0. The counter is loaded with `SETTLE_CYC`−1 on every code change or reload.
- Full acquisition takes 6 sample points: 6×`SETTLE_CYC` cycles after the `enable` edge, plus 1 cycle to enter SAR.
- A coarse request asserts 1 cycle after the triggering sample point.
- The request deasserts on the edge after `coarse_ack` is sampled high. `coarse_ack` arriving the same cycle the request first asserts is not seen; it is sampled from the next edge onward.
- `coarse_inc` and `coarse_dec` are never both 1.

## Structure
- Shared package `fdl_pkg`: state enum (IDLE, SAR, TRACK, COARSE), move enum (UP, DN, HOLD), `FDL_W`=6, `MID_CODE` default.
- One sub-module `fdl_lock_det`: reversal counter, last-direction register and `locked` flag. Inputs: move strobe, direction, clear.

## Test plan
- Reset: `rst_n`=0 → `Q`=32, `Qb`=31, `locked`=0, both coarse requests 0.
- SAR: PD model with target code 45 (`SETTLE_CYC`=8) → `Q` sequence 32, 48, 40, 44, 46, 45. TRACK is entered 49 cycles after enable.
- Lock: in TRACK, drive alternating UP/DN with `LOCK_CNT`=4 → `locked`=1 after the 4th reversal. Two consecutive UPs → `locked`=0.
- Range limit: hold `pd_up`=1 from `Q`=60 → `Q` reaches 63, then `coarse_inc`=1. Ack after 5 cycles → request drops the next edge, `Q`=32.
- Both or neither PD inputs high in TRACK → `Q` unchanged, settle restarts, lock state unchanged.
- Interruption: `enable`=0 mid-SAR and separately during a COARSE request → IDLE next edge, requests 0. Separately, `rst_n`=0 mid-COARSE → full reset values.

Source files
------------

// File: rtl/fdl_pkg.sv
// fdl_pkg: shared types and constants for the fine delay line controller.
// Holds the FSM state enum, the phase-detector move enum and the code width.
package fdl_pkg;

    localparam int unsigned FDL_W = 6;
    localparam int unsigned IDX_W = $clog2(FDL_W);
    localparam logic [FDL_W-1:0] MID_CODE_DEF = 6'd32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAR,
        S_TRACK,
        S_COARSE
    } state_t;

    typedef enum logic [1:0] {
        MV_UP,
        MV_DN,
        MV_HOLD
    } move_t;

    // Both or neither detector output high carries no information.
    function automatic move_t decode_move(input logic up, input logic dn);
        move_t mv;
        mv = MV_HOLD;
        if (up && !dn) begin
            mv = MV_UP;
        end else if (dn && !up) begin
            mv = MV_DN;
        end
        return mv;
    endfunction

endpackage

// File: rtl/fdl_lock_det.sv
// fdl_lock_det: counts direction reversals of accepted tracking moves.
// Ports: clk_i, rst_ni (sync), stb_i move strobe, up_i direction, clr_i, locked_o.
module fdl_lock_det #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic up_i,
    input  logic clr_i,
    output logic locked_o
);

    localparam int unsigned CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] LIM = CW'(LOCK_CNT);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          vld_q, vld_d;
    logic          lock_q, lock_d;

    // vld_q marks that a previous move exists to compare against.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        vld_d  = vld_q;
        lock_d = lock_q;
        if (clr_i) begin
            cnt_d  = '0;
            vld_d  = 1'b0;
            lock_d = 1'b0;
        end else if (stb_i) begin
            vld_d  = 1'b1;
            last_d = up_i;
            if (vld_q && (up_i != last_q)) begin
                if (cnt_q != LIM) begin
                    cnt_d = cnt_q + ONE;
                end
                lock_d = (cnt_d == LIM);
            end else if (vld_q) begin
                cnt_d  = '0;
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            vld_q  <= vld_d;
            lock_q <= lock_d;
        end
    end

    assign locked_o = lock_q;

endmodule

// File: rtl/fdl_ctrl.sv
// fdl_ctrl: fine delay line sequencer - SAR acquisition, +/-1 tracking,
// lock detection and coarse-step request/acknowledge.
// Ports: clk_in, rst_n (sync, active-low), enable, pd_up/pd_dn (synchronized
// phase detector), coarse_ack; Q/Qb complementary code, locked,
// coarse_inc/coarse_dec level requests held until acknowledged.
module fdl_ctrl
    import fdl_pkg::*;
#(
    parameter int unsigned      SETTLE_CYC = 8,
    parameter int unsigned      LOCK_CNT   = 4,
    parameter logic [FDL_W-1:0] MID_CODE   = MID_CODE_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pd_up,
    input  logic             pd_dn,
    input  logic             coarse_ack,
    output logic [FDL_W-1:0] Q,
    output logic [FDL_W-1:0] Qb,
    output logic             locked,
    output logic             coarse_inc,
    output logic             coarse_dec
);

    localparam int unsigned CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [FDL_W-1:0] CODE_MAX = '1;
    localparam logic [FDL_W-1:0] CODE_ONE = FDL_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(FDL_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           st_q, st_d;
    logic [FDL_W-1:0] code_q, code_d;
    logic [FDL_W-1:0] qb_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    move_t            mv;
    logic             smp;
    logic             mv_stb;
    logic             mv_up;
    logic             lk_clr;

    assign mv    = decode_move(pd_up, pd_dn);
    assign smp   = (cnt_q == '0);
    assign mv_up = (mv == MV_UP);
    // Leaving TRACK for any other state wipes the lock history.
    assign lk_clr = (st_d != S_TRACK);

    always_comb begin
        st_d   = st_q;
        code_d = code_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        inc_d  = inc_q;
        dec_d  = dec_q;
        mv_stb = 1'b0;
        if (!enable) begin
            st_d  = S_IDLE;
            inc_d = 1'b0;
            dec_d = 1'b0;
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    code_d = MID_CODE;
                    idx_d  = IDX_TOP;
                    cnt_d  = RELOAD;
                    st_d   = S_SAR;
                end
                S_SAR: begin
                    if (smp) begin
                        if (mv == MV_DN) begin
                            code_d[idx_q] = 1'b0;
                        end
                        cnt_d = RELOAD;
                        if (idx_q != '0) begin
                            code_d[idx_q - IDX_ONE] = 1'b1;
                            idx_d = idx_q - IDX_ONE;
                        end else begin
                            st_d = S_TRACK;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_TRACK: begin
                    if (smp) begin
                        cnt_d = RELOAD;
                        unique case (mv)
                            MV_UP: begin
                                if (code_q == CODE_MAX) begin
                                    st_d  = S_COARSE;
                                    inc_d = 1'b1;
                                end else begin
                                    code_d = code_q + CODE_ONE;
                                    mv_stb = 1'b1;
                                end
                            end
                            MV_DN: begin
                                if (code_q == '0) begin
                                    st_d  = S_COARSE;
                                    dec_d = 1'b1;
                                end else begin
                                    code_d = code_q - CODE_ONE;
                                    mv_stb = 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_COARSE: begin
                    if (coarse_ack) begin
                        inc_d  = 1'b0;
                        dec_d  = 1'b0;
                        code_d = MID_CODE;
                        cnt_d  = RELOAD;
                        st_d   = S_TRACK;
                    end
                end
            endcase
        end
    end

    // Qb is its own register so both halves switch on the same edge.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            code_q <= MID_CODE;
            qb_q   <= ~MID_CODE;
            cnt_q  <= '0;
            idx_q  <= IDX_TOP;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            code_q <= code_d;
            qb_q   <= ~code_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
        end
    end

    fdl_lock_det #(
        .LOCK_CNT(LOCK_CNT)
    ) u_lock (
        .clk_i   (clk_in),
        .rst_ni  (rst_n),
        .stb_i   (mv_stb),
        .up_i    (mv_up),
        .clr_i   (lk_clr),
        .locked_o(locked)
    );

    assign Q          = code_q;
    assign Qb         = qb_q;
    assign coarse_inc = inc_q;
    assign coarse_dec = dec_q;

endmodule

// File: tb/tb_fdl_ctrl.sv
// tb_fdl_ctrl: directed tables, corner sequences and random stimulus,
// all cross-checked every cycle against a behavioural controller model.
module tb_fdl_ctrl;

    localparam int S = 8;
    localparam int L = 4;
    localparam logic [5:0] MID = 6'd32;
    localparam int M_IDLE = 0;
    localparam int M_SAR = 1;
    localparam int M_TRACK = 2;
    localparam int M_COARSE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable, pd_up, pd_dn, coarse_ack;
    logic [5:0] Q, Qb;
    logic       locked, coarse_inc, coarse_dec;

    fdl_ctrl #(
        .SETTLE_CYC(S),
        .LOCK_CNT  (L),
        .MID_CODE  (MID)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pd_up     (pd_up),
        .pd_dn     (pd_dn),
        .coarse_ack(coarse_ack),
        .Q         (Q),
        .Qb        (Qb),
        .locked    (locked),
        .coarse_inc(coarse_inc),
        .coarse_dec(coarse_dec)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: integer code, SAR step number, cycles to next
    // sample, and the history of accepted moves since the last clear.
    int m_mode, m_code, m_step, m_wait;
    bit m_inc, m_dec;
    int hist[$];

    typedef struct {
        int edge_n;
        int exp_q;
    } vec_t;
    vec_t sar_tab[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Locked iff the last L+1 moves alternate (L consecutive reversals).
    function automatic bit m_locked();
        if (hist.size() < L + 1) return 1'b0;
        for (int i = 1; i < hist.size(); i++) begin
            if (hist[i] == hist[i-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_move(input int d);
        hist.push_back(d);
        if (hist.size() > L + 1) void'(hist.pop_front());
    endtask

    task automatic model_step();
        int mv;
        int w;
        mv = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_code = MID;
            m_wait = 0;
            m_inc = 0;
            m_dec = 0;
            hist.delete();
        end else if (!enable) begin
            m_mode = M_IDLE;
            m_inc = 0;
            m_dec = 0;
            hist.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_code = MID;
                    m_step = 0;
                    m_wait = S - 1;
                    m_mode = M_SAR;
                    hist.delete();
                end
                M_SAR: begin
                    if (m_wait > 0) m_wait--;
                    else begin
                        w = 1 << (5 - m_step);
                        if (mv < 0) m_code -= w;
                        if (m_step < 5) m_code += w / 2;
                        else m_mode = M_TRACK;
                        m_step++;
                        m_wait = S - 1;
                    end
                end
                M_TRACK: begin
                    if (m_wait > 0) m_wait--;
                    else begin
                        m_wait = S - 1;
                        if (mv > 0 && m_code == 63) begin
                            m_mode = M_COARSE;
                            m_inc = 1;
                            hist.delete();
                        end else if (mv < 0 && m_code == 0) begin
                            m_mode = M_COARSE;
                            m_dec = 1;
                            hist.delete();
                        end else if (mv != 0) begin
                            m_code += mv;
                            push_move(mv);
                        end
                    end
                end
                default: begin
                    if (coarse_ack) begin
                        m_inc = 0;
                        m_dec = 0;
                        m_code = MID;
                        m_wait = S - 1;
                        m_mode = M_TRACK;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("Q", Q, m_code);
        chk("Qb", Qb, (~m_code) & 63);
        chk("locked", locked, m_locked());
        chk("coarse_inc", coarse_inc, m_inc);
        chk("coarse_dec", coarse_dec, m_dec);
    endtask

    task automatic move(input bit u, input bit d);
        pd_up = u;
        pd_dn = d;
        repeat (S) cycle();
    endtask

    task automatic wait_req(input bit want_inc, input int budget,
                            input string name);
        int n;
        n = 0;
        while (!(want_inc ? coarse_inc : coarse_dec) && n < budget) begin
            cycle();
            n++;
        end
        chk(name, n < budget, 1);
    endtask

    initial begin
        int tgt;
        int bias;
        rst_n = 0;
        enable = 0;
        pd_up = 0;
        pd_dn = 0;
        coarse_ack = 0;
        sar_tab = '{'{1, 32}, '{8, 32}, '{9, 48}, '{17, 40}, '{25, 44},
                    '{33, 46}, '{41, 45}, '{49, 45}, '{57, 46}};

        repeat (2) cycle();
        chk("rst_Q", Q, 32);
        chk("rst_Qb", Qb, 31);
        chk("rst_locked", locked, 0);
        chk("rst_inc", coarse_inc, 0);
        chk("rst_dec", coarse_dec, 0);
        rst_n = 1;
        cycle();
        chk("idle_hold_Q", Q, 32);

        // SAR acquisition toward code 45, then one tracking step up.
        tgt = 45;
        enable = 1;
        for (int e = 1; e <= 57; e++) begin
            if (e == 50) tgt = 47;
            pd_up = (Q < tgt);
            pd_dn = (Q > tgt);
            cycle();
            foreach (sar_tab[k]) begin
                if (sar_tab[k].edge_n == e) chk("sar_q", Q, sar_tab[k].exp_q);
            end
        end

        // Alternating moves build up reversals.
        move(0, 1);
        move(1, 0);
        move(0, 1);
        chk("lock_3rev", locked, 0);
        move(1, 0);
        chk("lock_4rev", locked, 1);
        chk("lock_q", Q, 46);
        move(1, 1);
        chk("both_q", Q, 46);
        chk("both_lock", locked, 1);
        move(0, 0);
        chk("none_q", Q, 46);
        chk("none_lock", locked, 1);
        move(1, 0);
        chk("same_dir_unlock", locked, 0);
        chk("same_dir_q", Q, 47);

        // Top of range, then acknowledged coarse step up.
        pd_up = 1;
        pd_dn = 0;
        wait_req(1, 400, "inc_timeout");
        chk("limit_q", Q, 63);
        chk("limit_dec", coarse_dec, 0);
        pd_up = 0;
        repeat (5) cycle();
        chk("inc_held", coarse_inc, 1);
        coarse_ack = 1;
        cycle();
        chk("inc_drop", coarse_inc, 0);
        chk("ack_q", Q, 32);

        // Ack already high when the request rises: seen one edge later.
        pd_dn = 1;
        wait_req(0, 400, "dec_timeout");
        chk("dec_q", Q, 0);
        cycle();
        chk("early_ack_drop", coarse_dec, 0);
        chk("early_ack_q", Q, 32);
        coarse_ack = 0;

        // Disable while a coarse request is pending.
        wait_req(0, 400, "dec2_timeout");
        pd_dn = 0;
        enable = 0;
        cycle();
        chk("dis_coarse_dec", coarse_dec, 0);
        chk("dis_coarse_q", Q, 0);
        chk("dis_coarse_lock", locked, 0);

        // Restart, then abort mid-SAR with Q held.
        enable = 1;
        pd_up = 1;
        cycle();
        chk("restart_q", Q, 32);
        repeat (20) cycle();
        chk("mid_sar_q", Q, 56);
        enable = 0;
        cycle();
        chk("dis_sar_q", Q, 56);
        chk("dis_sar_inc", coarse_inc, 0);

        // Reset while a coarse request is pending.
        enable = 1;
        wait_req(1, 200, "inc2_timeout");
        rst_n = 0;
        cycle();
        chk("rst_mid_Q", Q, 32);
        chk("rst_mid_Qb", Qb, 31);
        chk("rst_mid_inc", coarse_inc, 0);
        chk("rst_mid_lock", locked, 0);
        rst_n = 1;

        // Random traffic with biased detector phases.
        bias = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) bias = $urandom_range(0, 3);
            case (bias)
                0: begin
                    pd_up = 1'($urandom_range(0, 1));
                    pd_dn = 1'($urandom_range(0, 1));
                end
                1: begin
                    pd_up = 1;
                    pd_dn = ($urandom_range(0, 9) == 0);
                end
                2: begin
                    pd_dn = 1;
                    pd_up = ($urandom_range(0, 9) == 0);
                end
                default: begin
                    pd_up = 1'((c / S) % 2);
                    pd_dn = !pd_up;
                end
            endcase
            coarse_ack = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 299) != 0);
            rst_n = ($urandom_range(0, 999) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
